// File: rtl/tree_filler_mb_pkg.sv
// Shared types and sizing helpers for the multi-buffered tree filler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tree_filler_pkg;

  // Kind of record carried down the output pipeline.
  typedef enum logic {
    TAG_DATA = 1'b0,
    TAG_TERM = 1'b1
  } tag_e;

  // Terminal record; sliced down to the record width at the point of use.
  localparam int               TERM_MAX_W = 1024;
  localparam logic [TERM_MAX_W-1:0] TERM_REC = '1;

  // Width of one buffered line (all records of a line side by side).
  function automatic int line_w(input int datw, input int p_log);
    return datw << p_log;
  endfunction

  // Line-store address width: {way, slot}.
  function automatic int addr_w(input int w_log, input int b_log);
    return w_log + b_log;
  endfunction

endpackage

// File: rtl/tree_filler_mb_if.sv
// Request, line-write and record-output bundle of the tree filler.
// Latency: n/a (wires only).
// Backpressure: QUEUE_FULL and FUL are advisory; overruns are dropped and flagged on ERR.
interface tree_filler_mb_if #(
  parameter int W_LOG = 5,
  parameter int P_LOG = 3,
  parameter int DATW  = 64
) ();
  import tree_filler_pkg::*;

  logic [W_LOG-1:0]              I_REQUEST;
  logic                          I_REQUEST_VALID;
  logic [line_w(DATW,P_LOG)-1:0] DIN;
  logic                          DINEN;
  logic [W_LOG-1:0]              WADDR;
  logic [W_LOG-1:0]              FIN;
  logic                          FIN_VALID;
  logic                          QUEUE_FULL;
  logic [DATW-1:0]               DOT;
  logic                          DOTEN;
  logic [W_LOG-1:0]              DOT_IDX;
  logic [(1<<W_LOG)-1:0]         EMP;
  logic [(1<<W_LOG)-1:0]         FUL;
  logic                          ERR;

  modport master (
    output I_REQUEST, I_REQUEST_VALID, DIN, DINEN, WADDR, FIN, FIN_VALID,
    input  QUEUE_FULL, DOT, DOTEN, DOT_IDX, EMP, FUL, ERR
  );

  modport slave (
    input  I_REQUEST, I_REQUEST_VALID, DIN, DINEN, WADDR, FIN, FIN_VALID,
    output QUEUE_FULL, DOT, DOTEN, DOT_IDX, EMP, FUL, ERR
  );

endinterface

// File: rtl/tree_filler_mb_bram.sv
// Simple dual-port line store: one write port, one registered read port.
// Latency: read data valid one cycle after the read edge.
// Backpressure: none; accepts a read and a write every cycle.
module sdp_bram #(
  parameter int M_LOG = 6,
  parameter int DW    = 512
) (
  input  logic             clk,
  input  logic             we,
  input  logic [M_LOG-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [M_LOG-1:0] raddr,
  output logic [DW-1:0]    rdata
);
  logic [DW-1:0] mem [1<<M_LOG];

  // Write port and registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tree_filler_mb_req_fifo.sv
// Synchronous first-word-fall-through FIFO holding requested way indices.
// Latency: push visible at dout one cycle later; pop takes effect at the clock edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module req_fifo #(
  parameter int Q_LOG = 2,
  parameter int W_LOG = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W_LOG-1:0] din,
  input  logic             pop,
  output logic [W_LOG-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [Q_LOG:0]   count
);
  localparam int DEPTH = 1 << Q_LOG;

  logic [W_LOG-1:0] mem [DEPTH];
  logic [Q_LOG-1:0] wp;
  logic [Q_LOG-1:0] rp;
  logic             do_push;
  logic             do_pop;

  // Status flags and accept decisions; a pop frees the slot a full-queue push needs.
  always_comb begin
    empty   = (count == '0);
    full    = (count == (Q_LOG+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rp];
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + Q_LOG'(1);
      if (do_pop)  rp <= rp + Q_LOG'(1);
      if (do_push && !do_pop)      count <= count + (Q_LOG+1)'(1);
      else if (do_pop && !do_push) count <= count - (Q_LOG+1)'(1);
    end
  end

endmodule

// File: rtl/tree_filler_mb.sv
// Feeds the merge tree one record per cycle from per-way rings of buffered lines.
// Latency: dequeue cycle -> DOTEN two cycles later; 1 record/cycle sustained.
// Backpressure: head-of-line stall on an empty unfinished way; overruns dropped, ERR set.
module tree_filler_mb
  import tree_filler_pkg::*;
#(
  parameter int W_LOG = 5,
  parameter int P_LOG = 3,
  parameter int B_LOG = 1,
  parameter int Q_LOG = 2,
  parameter int DATW  = 64
) (
  input  logic           CLK,
  input  logic           RST,
  tree_filler_mb_if.slave bus
);
  localparam int NW = 1 << W_LOG;
  localparam int LW = line_w(DATW, P_LOG);
  localparam int AW = addr_w(W_LOG, B_LOG);
  localparam logic [B_LOG:0] LINES_MAX = (B_LOG+1)'(1 << B_LOG);

  logic [B_LOG-1:0] wr_ptr [NW];
  logic [B_LOG-1:0] rd_ptr [NW];
  logic [B_LOG:0]   lines  [NW];
  logic [P_LOG-1:0] rd_cnt [NW];
  logic [NW-1:0]    fin;

  logic [W_LOG-1:0] head;
  logic             q_full;
  logic             q_empty;
  logic [Q_LOG:0]   q_cnt;

  logic deq_data, deq_term, deq, wr_ok, line_done;
  logic [NW-1:0] inc_w, adv_w, dec_w;

  logic             s1_vld;
  tag_e             s1_tag;
  logic [P_LOG-1:0] s1_off;
  logic [W_LOG-1:0] s1_idx;
  logic [LW-1:0]    bram_rdata;

  req_fifo #(.Q_LOG(Q_LOG), .W_LOG(W_LOG)) u_req_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (bus.I_REQUEST_VALID),
    .din   (bus.I_REQUEST),
    .pop   (deq),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  sdp_bram #(.M_LOG(AW), .DW(LW)) u_bram (
    .clk   (CLK),
    .we    (wr_ok),
    .waddr ({bus.WADDR, wr_ptr[bus.WADDR]}),
    .wdata (bus.DIN),
    .re    (deq_data),
    .raddr ({head, rd_ptr[head]}),
    .rdata (bram_rdata)
  );

  assign bus.QUEUE_FULL = q_cnt[Q_LOG];

  // Head decision: serve buffered data, else a terminal for a finished way, else stall.
  always_comb begin
    deq_data  = !q_empty && (lines[head] != '0);
    deq_term  = !q_empty && (lines[head] == '0) && fin[head];
    deq       = deq_data || deq_term;
    wr_ok     = bus.DINEN && (lines[bus.WADDR] != LINES_MAX);
    line_done = deq_data && (rd_cnt[head] == {P_LOG{1'b1}});
    inc_w              = '0;
    adv_w              = '0;
    dec_w              = '0;
    inc_w[bus.WADDR]   = wr_ok;
    adv_w[head]        = deq_data;
    dec_w[head]        = line_done;
  end

  // Per-way empty/full status straight from the line counts.
  always_comb begin
    bus.EMP = '0;
    bus.FUL = '0;
    for (int w = 0; w < NW; w++) begin
      bus.EMP[w] = (lines[w] == '0);
      bus.FUL[w] = (lines[w] == LINES_MAX);
    end
  end

  // Ring pointers, line counts, record offsets and finish flags per way.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int w = 0; w < NW; w++) begin
        wr_ptr[w] <= '0;
        rd_ptr[w] <= '0;
        lines[w]  <= '0;
        rd_cnt[w] <= '0;
      end
      fin <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (inc_w[w]) wr_ptr[w] <= wr_ptr[w] + B_LOG'(1);
        if (adv_w[w]) rd_cnt[w] <= rd_cnt[w] + P_LOG'(1);
        if (dec_w[w]) rd_ptr[w] <= rd_ptr[w] + B_LOG'(1);
        if (inc_w[w] && !dec_w[w])      lines[w] <= lines[w] + (B_LOG+1)'(1);
        else if (dec_w[w] && !inc_w[w]) lines[w] <= lines[w] - (B_LOG+1)'(1);
      end
      if (bus.FIN_VALID) fin[bus.FIN] <= 1'b1;
    end
  end

  // Sticky error on a write to a full way or an enqueue the queue cannot take.
  always_ff @(posedge CLK) begin
    if (RST) bus.ERR <= 1'b0;
    else if ((bus.DINEN && !wr_ok) ||
             (bus.I_REQUEST_VALID && q_full && !deq)) bus.ERR <= 1'b1;
  end

  // Two-stage output pipe: line read in flight, then record select.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld      <= 1'b0;
      s1_tag      <= TAG_DATA;
      s1_off      <= '0;
      s1_idx      <= '0;
      bus.DOTEN   <= 1'b0;
      bus.DOT     <= '0;
      bus.DOT_IDX <= '0;
    end else begin
      s1_vld    <= deq;
      s1_tag    <= deq_term ? TAG_TERM : TAG_DATA;
      s1_off    <= rd_cnt[head];
      s1_idx    <= head;
      bus.DOTEN <= s1_vld;
      if (s1_vld) begin
        bus.DOT     <= (s1_tag == TAG_TERM) ? TERM_REC[DATW-1:0]
                                            : bram_rdata[s1_off*DATW +: DATW];
        bus.DOT_IDX <= s1_idx;
      end
    end
  end

endmodule
